// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction memory loader. Parses a length-prefixed,
//               XOR-checksummed byte stream, writes words from address 0 and
//               releases the processor reset once an image loads cleanly.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [15:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_resetn
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LEN_HI  = 3'd1;
    localparam logic [2:0] c_ST_LEN_LO  = 3'd2;
    localparam logic [2:0] c_ST_DATA_HI = 3'd3;
    localparam logic [2:0] c_ST_DATA_LO = 3'd4;
    localparam logic [2:0] c_ST_CHK     = 3'd5;
    localparam logic [2:0] c_ST_DONE    = 3'd6;
    localparam logic [2:0] c_ST_ERROR   = 3'd7;

    localparam logic [16:0]         c_MAX_LEN = 17'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] c_ONE     = (ADDR_WIDTH + 1)'(1);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic                  r_s_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [15:0]           r_imem_wdata;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic [ADDR_WIDTH:0]   r_len;
    logic [7:0]            r_len_hi;
    logic [7:0]            r_data_hi;
    logic [7:0]            r_chk;

    logic                  w_xfer;
    logic                  w_start_ok;
    logic                  w_active_next;
    logic [15:0]           w_len;
    logic                  w_oversize;
    logic                  w_last_word;

    assign w_xfer        = s_valid & r_s_ready;
    assign w_start_ok    = start & ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE) ||
                                    (r_state == c_ST_ERROR));
    assign w_len         = {r_len_hi, s_data};
    assign w_oversize    = {1'b0, w_len} > c_MAX_LEN;
    assign w_last_word   = (r_word_count + c_ONE) == r_len;
    assign w_active_next = (w_next_state >= c_ST_LEN_HI) && (w_next_state <= c_ST_CHK);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERROR: begin
                if (w_start_ok) w_next_state = c_ST_LEN_HI;
            end
            c_ST_LEN_HI: begin
                if (w_xfer) w_next_state = c_ST_LEN_LO;
            end
            c_ST_LEN_LO: begin
                if (w_xfer) begin
                    if (w_oversize)          w_next_state = c_ST_ERROR;
                    else if (w_len == 16'd0) w_next_state = c_ST_CHK;
                    else                     w_next_state = c_ST_DATA_HI;
                end
            end
            c_ST_DATA_HI: begin
                if (w_xfer) w_next_state = c_ST_DATA_LO;
            end
            c_ST_DATA_LO: begin
                if (w_xfer) w_next_state = w_last_word ? c_ST_CHK : c_ST_DATA_HI;
            end
            c_ST_CHK: begin
                if (w_xfer) w_next_state = (s_data == r_chk) ? c_ST_DONE : c_ST_ERROR;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they are clean flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s_ready    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_word_count <= '0;
            r_len        <= '0;
            r_len_hi     <= '0;
            r_data_hi    <= '0;
            r_chk        <= '0;
        end else begin
            r_s_ready <= w_active_next;
            r_busy    <= w_active_next;
            r_done    <= (w_next_state == c_ST_DONE);
            r_err     <= (w_next_state == c_ST_ERROR);
            r_imem_we <= 1'b0;
            if (w_start_ok) begin
                r_word_count <= '0;
                r_chk        <= '0;
            end
            if (w_xfer) begin
                case (r_state)
                    c_ST_LEN_HI: r_len_hi <= s_data;
                    c_ST_LEN_LO: r_len    <= w_len[ADDR_WIDTH:0];
                    c_ST_DATA_HI: begin
                        r_data_hi <= s_data;
                        r_chk     <= r_chk ^ s_data;
                    end
                    c_ST_DATA_LO: begin
                        r_chk        <= r_chk ^ s_data;
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_word_count[ADDR_WIDTH-1:0];
                        r_imem_wdata <= {r_data_hi, s_data};
                        r_word_count <= r_word_count + c_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_ready    = r_s_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign cpu_resetn = r_done;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader: expected writes are queued as
//               streams are driven and checked as the loader emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int AW = 8;

    typedef logic [7:0]  bq_t[$];
    typedef logic [32:0] wr_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic          err;
    logic          cpu_resetn;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_resetn (cpu_resetn)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_t got;
            wr_t want;
            got = {imem_addr, imem_wdata, word_count};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%h data=%h count=%0d, need no write",
                         imem_addr, imem_wdata, word_count);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL write_value: got addr=%h data=%h count=%0d, need addr=%h data=%h count=%0d",
                             got[32:25], got[24:9], got[8:0], want[32:25], want[24:9], want[8:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap, input bit mid_start);
        int gap;
        bit ok;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int i = 0; i < gap; i++) begin
            s_valid = 1'b0;
            start   = mid_start && ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
        end
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        ok      = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = s_ready;
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_accept: got s_ready=0 for 50 cycles, need 1 (byte %h)", b);
        end
        s_valid = 1'b0;
    endtask

    task automatic send_stream(input bq_t b, input int max_gap, input bit mid_start);
        int n;
        n = int'({b[0], b[1]});
        if (n <= (1 << AW)) begin
            for (int w = 0; w < n; w++)
                exp_q.push_back({AW'(w), b[2 + 2 * w], b[3 + 2 * w], (AW + 1)'(w + 1)});
        end
        pulse_start();
        foreach (b[i]) send_byte(b[i], max_gap, mid_start);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({s_ready, imem_we, imem_addr, imem_wdata, word_count, busy, done, err, cpu_resetn} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%h data=%h cnt=%0d busy=%b done=%b err=%b cpu=%b, need all 0",
                     s_ready, imem_we, imem_addr, imem_wdata, word_count, busy, done, err, cpu_resetn);
        end
        resetn  = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({s_ready, busy, done, cpu_resetn} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_ignores_bytes: got ready=%b busy=%b done=%b cpu=%b, need 0000",
                     s_ready, busy, done, cpu_resetn);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_good_load(input int max_gap, input bit mid_start);
        send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, max_gap, mid_start);
        n_tests++;
        if ({busy, done, err, cpu_resetn, word_count} !== {4'b0101, 9'd2}) begin
            n_fail++;
            $display("FAIL good_load_status: got busy=%b done=%b err=%b cpu=%b cnt=%0d, need 0 1 0 1 cnt=2",
                     busy, done, err, cpu_resetn, word_count);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL good_load_writes: got %0d writes missing, need 0", exp_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41}, 0, 1'b0);
        n_tests++;
        if ({busy, done, err, cpu_resetn, word_count} !== {4'b0010, 9'd2}) begin
            n_fail++;
            $display("FAIL bad_chk_status: got busy=%b done=%b err=%b cpu=%b cnt=%0d, need 0 0 1 0 cnt=2",
                     busy, done, err, cpu_resetn, word_count);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bad_chk_writes: got %0d writes missing, need 0", exp_q.size());
        end
    endtask

    task automatic test_oversize();
        send_stream('{8'h01, 8'h01}, 0, 1'b0);
        n_tests++;
        if ({busy, done, err, cpu_resetn, s_ready} !== 5'b00100) begin
            n_fail++;
            $display("FAIL oversize_status: got busy=%b done=%b err=%b cpu=%b ready=%b, need 0 0 1 0 0",
                     busy, done, err, cpu_resetn, s_ready);
        end
    endtask

    task automatic test_zero_length();
        send_stream('{8'h00, 8'h00, 8'h00}, 0, 1'b0);
        n_tests++;
        if ({done, err, cpu_resetn, word_count} !== {3'b101, 9'd0}) begin
            n_fail++;
            $display("FAIL zero_len_good: got done=%b err=%b cpu=%b cnt=%0d, need 1 0 1 cnt=0",
                     done, err, cpu_resetn, word_count);
        end
        send_stream('{8'h00, 8'h00, 8'h01}, 0, 1'b0);
        n_tests++;
        if ({done, err, cpu_resetn, word_count} !== {3'b010, 9'd0}) begin
            n_fail++;
            $display("FAIL zero_len_bad: got done=%b err=%b cpu=%b cnt=%0d, need 0 1 0 cnt=0",
                     done, err, cpu_resetn, word_count);
        end
    endtask

    task automatic test_max_length();
        bq_t b;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] chk;
        b.push_back(8'h01);
        b.push_back(8'h00);
        chk = 8'h00;
        for (int w = 0; w < (1 << AW); w++) begin
            hi = 8'(w);
            lo = 8'(w * 7 + 3);
            b.push_back(hi);
            b.push_back(lo);
            chk = chk ^ hi ^ lo;
        end
        b.push_back(chk);
        send_stream(b, 0, 1'b0);
        n_tests++;
        if ({done, err, cpu_resetn, word_count, imem_addr} !== {3'b101, 9'd256, 8'hFF}) begin
            n_fail++;
            $display("FAIL max_len_status: got done=%b err=%b cpu=%b cnt=%0d addr=%h, need 1 0 1 cnt=256 addr=ff",
                     done, err, cpu_resetn, word_count, imem_addr);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL max_len_writes: got %0d writes missing, need 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        exp_q.push_back({8'h00, 16'h1234, 9'd1});
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        n_tests++;
        if ({s_ready, imem_we, imem_addr, imem_wdata, word_count, busy, done, err, cpu_resetn} !== '0) begin
            n_fail++;
            $display("FAIL midload_reset_outputs: got ready=%b we=%b addr=%h data=%h cnt=%0d busy=%b done=%b err=%b cpu=%b, need all 0",
                     s_ready, imem_we, imem_addr, imem_wdata, word_count, busy, done, err, cpu_resetn);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midload_first_write: got %0d writes missing, need 0", exp_q.size());
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        test_good_load(0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_good_load(0, 1'b0);
        test_bad_checksum();
        test_oversize();
        test_zero_length();
        test_good_load(3, 1'b1);
        test_max_length();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
